// File: rtl/prog_launch_sequencer_if.sv
// Run-control bundle between the bench/top level and the launch sequencer.
// master drives Start/Done and observes the PC-control outputs; slave is the sequencer.
interface prog_launch_sequencer_if #(
  parameter int unsigned L  = 10,
  parameter int unsigned CW = 16
);
  logic          Start;
  logic          Done;
  logic          Hold;
  logic          Launch;
  logic [L-1:0]  Target;
  logic [1:0]    ProgSel;
  logic          Busy;
  logic          Ack;
  logic          Timeout;
  logic [CW-1:0] LastCycles;

  modport master (
    output Start, Done,
    input  Hold, Launch, Target, ProgSel, Busy, Ack, Timeout, LastCycles
  );

  modport slave (
    input  Start, Done,
    output Hold, Launch, Target, ProgSel, Busy, Ack, Timeout, LastCycles
  );
endinterface

// File: rtl/prog_launch_sequencer.sv
// Run controller for the 9-bit-ISA core: converts the Start/Done handshake into
// PC control (hold, one-cycle absolute jump to each program's entry), runs
// programs 1..3 in order, times each run and aborts it on a watchdog limit.
module prog_launch_sequencer #(
  parameter int unsigned L        = 10,
  parameter int unsigned CW       = 16,
  parameter int unsigned P1_ENTRY = 2,
  parameter int unsigned P2_ENTRY = 321,
  parameter int unsigned P3_ENTRY = 324,
  parameter int unsigned MAX_CYC  = 4096
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  prog_launch_sequencer_if.slave bus
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CW;
  localparam longint unsigned PC_SPAN  = 64'd1 << L;

  // Parameter sanity: the watchdog limit must be reachable by the counter and
  // every entry address must be representable on the PC.
  if (MAX_CYC < 1 || longint'(MAX_CYC) - 1 >= longint'(CNT_SPAN)) begin : g_bad_max_cyc
    $error("MAX_CYC-1 does not fit in CW bits");
  end
  if (longint'(P1_ENTRY) >= longint'(PC_SPAN) ||
      longint'(P2_ENTRY) >= longint'(PC_SPAN) ||
      longint'(P3_ENTRY) >= longint'(PC_SPAN)) begin : g_bad_entry
    $error("program entry address does not fit in L bits");
  end

  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_CYC - 1);
  localparam logic [L-1:0]  ENTRY0  = L'(P1_ENTRY);
  localparam logic [L-1:0]  ENTRY1  = L'(P2_ENTRY);
  localparam logic [L-1:0]  ENTRY2  = L'(P3_ENTRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LAUNCH,
    S_RUN,
    S_FINISH,
    S_ALLDONE
  } state_t;

  state_t        state, state_nxt;
  logic          start_q;
  logic          start_rise, start_fall;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] last, last_nxt;
  logic          ack, ack_nxt;
  logic          tmo, tmo_nxt;

  function automatic logic [L-1:0] entry_of(input logic [1:0] i);
    case (i)
      2'd0:    entry_of = ENTRY0;
      2'd1:    entry_of = ENTRY1;
      default: entry_of = ENTRY2;
    endcase
  endfunction

  assign start_rise = bus.Start & ~start_q;
  assign start_fall = ~bus.Start & start_q;

  // State and run bookkeeping registers; reset is immediate so a stuck program
  // can be abandoned mid-RUN.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      idx     <= 2'd0;
      cnt     <= '0;
      last    <= '0;
      ack     <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= bus.Start;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      ack     <= ack_nxt;
      tmo     <= tmo_nxt;
    end
  end

  // Next-state, bookkeeping updates and PC-control outputs.
  // Completion status (Ack/LastCycles/Timeout) is captured on the RUN exit so it
  // is already visible in FINISH; the program index advances on the FINISH exit.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    last_nxt       = last;
    ack_nxt        = ack;
    tmo_nxt        = tmo;
    bus.Hold       = 1'b1;
    bus.Launch     = 1'b0;
    bus.Target     = '0;
    bus.Busy       = 1'b0;
    bus.ProgSel    = idx;
    bus.Ack        = ack;
    bus.Timeout    = tmo;
    bus.LastCycles = last;

    case (state)
      S_IDLE: begin
        if (start_rise) begin
          state_nxt = S_ARMED;
          ack_nxt   = 1'b0;
        end
      end
      S_ARMED: begin
        if (start_fall) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.Hold   = 1'b0;
        bus.Launch = 1'b1;
        bus.Target = entry_of(idx);
        bus.Busy   = 1'b1;
        cnt_nxt    = '0;
        tmo_nxt    = 1'b0;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        bus.Hold = 1'b0;
        bus.Busy = 1'b1;
        // Done takes priority over the watchdog; the count saturates at the
        // limit because the run ends there.
        if (bus.Done) begin
          state_nxt = S_FINISH;
          last_nxt  = cnt;
          ack_nxt   = 1'b1;
        end else if (cnt == CNT_LIM) begin
          state_nxt = S_FINISH;
          last_nxt  = cnt;
          ack_nxt   = 1'b1;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_FINISH: begin
        if (idx == 2'd2) begin
          state_nxt = S_ALLDONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = S_IDLE;
        end
      end
      S_ALLDONE: begin
        state_nxt = S_ALLDONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_launch_sequencer.sv
// Randomized scoreboard bench for prog_launch_sequencer: the driver issues
// Start/Done sessions and queues the expected launch/finish events; a monitor
// pops and compares each event as the sequencer presents it.
module tb_prog_launch_sequencer;

  localparam int L       = 10;
  localparam int CW      = 16;
  localparam int MAX_CYC = 8;
  localparam int MAX_K   = 10;

  logic Clk;
  logic Reset_n;

  prog_launch_sequencer_if #(.L(L), .CW(CW)) bus ();

  prog_launch_sequencer #(
    .L(L), .CW(CW), .P1_ENTRY(2), .P2_ENTRY(321), .P3_ENTRY(324), .MAX_CYC(MAX_CYC)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit is_launch;
    int target;
    int last;
    bit tmo;
    int sel;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   entries[3] = '{2, 321, 324};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares each Launch pulse and each end-of-run against the queue.
  bit prev_busy = 0;
  bit sel_pend  = 0;
  bit tmo_pend  = 0;
  int exp_sel   = 0;

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      prev_busy = 0;
      sel_pend  = 0;
      tmo_pend  = 0;
    end else begin
      if (sel_pend) begin
        chk("progsel_after_finish", 32'(bus.ProgSel), exp_sel);
        sel_pend = 0;
      end
      if (tmo_pend) begin
        chk("timeout_cleared_by_launch", 32'(bus.Timeout), 0);
        tmo_pend = 0;
      end
      if (bus.Launch) begin
        if (q.size() == 0 || !q[0].is_launch) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_launch: got target %0d expected no launch at %0t",
                   bus.Target, $time);
        end else begin
          e = q.pop_front();
          chk("launch_target", 32'(bus.Target), e.target);
          chk("launch_hold", 32'(bus.Hold), 0);
          chk("launch_ack", 32'(bus.Ack), 0);
          tmo_pend = 1;
        end
      end
      if (prev_busy && !bus.Busy) begin
        if (q.size() == 0 || q[0].is_launch) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_finish: got last %0d expected no finish at %0t",
                   bus.LastCycles, $time);
        end else begin
          e = q.pop_front();
          chk("finish_lastcycles", 32'(bus.LastCycles), e.last);
          chk("finish_timeout", 32'(bus.Timeout), e.tmo);
          chk("finish_ack", 32'(bus.Ack), 1);
          chk("finish_hold", 32'(bus.Hold), 1);
          exp_sel  = e.sel;
          sel_pend = 1;
        end
      end
      prev_busy = bus.Busy;
    end
  end

  // Reference: a run whose Done arrives after k RUN cycles reports k, unless
  // the watchdog (MAX_CYC cycles) expires first.
  function automatic exp_t model_finish(input int i, input int k);
    exp_t e;
    e.is_launch = 0;
    e.target    = 0;
    e.tmo       = (k >= MAX_CYC);
    e.last      = (k >= MAX_CYC) ? MAX_CYC - 1 : k;
    e.sel       = (i < 2) ? i + 1 : 2;
    return e;
  endfunction

  function automatic exp_t model_launch(input int i);
    exp_t e;
    e.is_launch = 1;
    e.target    = entries[i];
    e.last      = 0;
    e.tmo       = 0;
    e.sel       = 0;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset_n  = 1'b0;
    bus.Start = 1'b0;
    bus.Done  = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_hold", 32'(bus.Hold), 1);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_launch", 32'(bus.Launch), 0);
    chk("rst_target", 32'(bus.Target), 0);
    chk("rst_progsel", 32'(bus.ProgSel), 0);
    chk("rst_ack", 32'(bus.Ack), 0);
    chk("rst_timeout", 32'(bus.Timeout), 0);
    chk("rst_lastcycles", 32'(bus.LastCycles), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  // Start pulse of w cycles; Done is glitched while armed. Returns at the
  // negedge where Start is lowered (fall sampled at the next posedge).
  task automatic start_pulse(input int w);
    @(negedge Clk);
    bus.Start = 1'b1;
    for (int h = 1; h < w; h++) begin
      @(negedge Clk);
      if (h == 1) bus.Done = 1'b1;
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Done  = 1'b0;
  endtask

  // One program: Done reaches the sequencer after k RUN cycles; Start is
  // toggled randomly while the run is still in progress.
  task automatic run_prog(input int i, input int k, input int w);
    int stop_j;
    q.push_back(model_launch(i));
    q.push_back(model_finish(i, k));
    start_pulse(w);
    stop_j = 2 + ((k < MAX_CYC - 1) ? k : MAX_CYC - 1);
    for (int j = 1; j <= 2 + k; j++) begin
      @(negedge Clk);
      if (j >= 2 && j < stop_j) bus.Start = 1'($urandom_range(0, 1));
      if (j == stop_j) bus.Start = 1'b0;
      if (j == 2 + k) bus.Done = 1'b1;
    end
    repeat ($urandom_range(1, 2)) @(negedge Clk);
    bus.Done  = 1'b0;
    bus.Start = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic alldone_check(input int last_exp);
    start_pulse(2);
    repeat (8) @(negedge Clk);
    chk("alldone_ack", 32'(bus.Ack), 1);
    chk("alldone_hold", 32'(bus.Hold), 1);
    chk("alldone_busy", 32'(bus.Busy), 0);
    chk("alldone_progsel", 32'(bus.ProgSel), 2);
    chk("alldone_lastcycles", 32'(bus.LastCycles), last_exp);
  endtask

  task automatic session(input int k0, input int k1, input int k2);
    exp_t f;
    do_reset();
    run_prog(0, k0, $urandom_range(1, 4));
    run_prog(1, k1, $urandom_range(1, 4));
    run_prog(2, k2, $urandom_range(1, 4));
    f = model_finish(2, k2);
    alldone_check(f.last);
    chk("session_queue_drained", 32'(q.size()), 0);
  endtask

  // Reset asserted mid-RUN of the second program takes effect immediately.
  task automatic reset_mid_run();
    do_reset();
    run_prog(0, 3, 2);
    q.push_back(model_launch(1));
    start_pulse(1);
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrun_rst_hold", 32'(bus.Hold), 1);
    chk("midrun_rst_busy", 32'(bus.Busy), 0);
    chk("midrun_rst_launch", 32'(bus.Launch), 0);
    chk("midrun_rst_progsel", 32'(bus.ProgSel), 0);
    chk("midrun_rst_lastcycles", 32'(bus.LastCycles), 0);
    chk("midrun_rst_ack", 32'(bus.Ack), 0);
    chk("midrun_queue_drained", 32'(q.size()), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    Reset_n   = 1'b0;
    bus.Start = 1'b0;
    bus.Done  = 1'b0;
    session(10, 3, MAX_CYC - 1);
    reset_mid_run();
    session(0, MAX_CYC, 1);
    for (int s = 0; s < 6; s++) begin
      session($urandom_range(0, MAX_K), $urandom_range(0, MAX_K), $urandom_range(0, MAX_K));
    end
    chk("final_queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
